// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: two-client round-robin SPI master for a 16-bit
// posedge-only slave. Each frame issues PRE_CLKS preamble SCK cycles with
// CSbar high, then 17 SCK cycles with CSbar low (pad bit + 16 data bits).
module spi_master_arbiter #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned PRE_CLKS = 2,
    parameter int unsigned GAP      = 8
) (
    input  logic        CLK_50,
    input  logic        RST,
    input  logic [1:0]  REQ,
    input  logic [15:0] TX_DATA0,
    input  logic [15:0] TX_DATA1,
    output logic [1:0]  GNT,
    output logic [1:0]  DONE,
    output logic [15:0] RX_DATA,
    output logic        BUSY,
    output logic        SCK,
    output logic        CSbar,
    output logic        MOSI,
    input  logic        MISO
);

    // At least one preamble cycle and one POST cycle (the DONE cycle) always exist.
    localparam int unsigned PRE_N = (PRE_CLKS > 0) ? PRE_CLKS : 1;
    localparam int unsigned GAP_N = (GAP > 0) ? GAP : 1;
    localparam int unsigned DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PW    = (PRE_N > 1) ? $clog2(PRE_N) : 1;
    localparam int unsigned GW    = (GAP_N > 1) ? $clog2(GAP_N) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRE_N - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        SHIFT = 2'd2,
        POST  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [DW-1:0] r_div;
    logic [PW-1:0] r_pre;
    logic [4:0]    r_bit;
    logic [GW-1:0] r_gap;
    logic [16:0]   r_shift;
    logic [15:0]   r_rx;
    logic [15:0]   r_rx_data;
    logic [1:0]    r_gnt;
    logic [1:0]    r_done;
    logic          r_last;
    logic          r_sck;
    logic          r_csbar;
    logic          r_mosi;

    logic          w_tick;
    logic          w_rise;
    logic          w_fall;
    logic          w_pick;

    assign w_tick = (r_div == DIV_LAST);
    assign w_rise = w_tick & ~r_sck;
    assign w_fall = w_tick & r_sck;

    assign DONE    = r_done;
    assign RX_DATA = r_rx_data;
    assign SCK     = r_sck;
    assign CSbar   = r_csbar;
    assign MOSI    = r_mosi;

    // Arbitration pick, next-state decode and grant/busy outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_pick      = 1'b0;
        GNT         = r_gnt;
        BUSY        = (r_state != IDLE);

        if (REQ == 2'b11) begin
            w_pick = ~r_last;
        end else begin
            w_pick = REQ[1];
        end

        case (r_state)
            IDLE: begin
                if (|REQ) begin
                    w_state_nxt = PRE;
                    // Grant is visible in the IDLE cycle that sees the request;
                    // RST gates it so a held request shows no grant during reset.
                    if (!RST) begin
                        GNT = w_pick ? 2'b10 : 2'b01;
                    end
                end
            end
            PRE: begin
                if (w_fall && (r_pre == PRE_LAST)) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_fall && (r_bit == 5'd16)) begin
                    w_state_nxt = POST;
                end
            end
            POST: begin
                if (r_gap == GAP_LAST) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // SCK generation, shift/capture datapath, grant and done registers.
    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) begin
            r_div     <= '0;
            r_pre     <= '0;
            r_bit     <= '0;
            r_gap     <= '0;
            r_shift   <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_last    <= 1'b1;
            r_sck     <= 1'b0;
            r_csbar   <= 1'b1;
            r_mosi    <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    r_div   <= '0;
                    r_pre   <= '0;
                    r_bit   <= '0;
                    r_gap   <= '0;
                    r_sck   <= 1'b0;
                    r_csbar <= 1'b1;
                    r_mosi  <= 1'b0;
                    if (|REQ) begin
                        r_last  <= w_pick;
                        r_gnt   <= w_pick ? 2'b10 : 2'b01;
                        r_shift <= {1'b0, (w_pick ? TX_DATA1 : TX_DATA0)};
                    end
                end
                PRE, SHIFT: begin
                    r_div <= w_tick ? '0 : r_div + 1'b1;
                    if (w_tick) begin
                        r_sck <= ~r_sck;
                    end
                    if (r_state == PRE) begin
                        if (w_fall) begin
                            r_pre <= r_pre + 1'b1;
                            if (r_pre == PRE_LAST) begin
                                r_csbar <= 1'b0;
                                r_mosi  <= r_shift[16];
                            end
                        end
                    end else begin
                        // Sample before rising edge 1 is stale and dropped.
                        if (w_rise && (r_bit != 5'd0)) begin
                            r_rx <= {r_rx[14:0], MISO};
                        end
                        if (w_fall) begin
                            if (r_bit == 5'd16) begin
                                r_csbar   <= 1'b1;
                                r_mosi    <= 1'b0;
                                r_done    <= r_gnt;
                                r_rx_data <= r_rx;
                                r_gap     <= '0;
                            end else begin
                                r_bit   <= r_bit + 5'd1;
                                r_shift <= {r_shift[15:0], 1'b0};
                                r_mosi  <= r_shift[15];
                            end
                        end
                    end
                end
                POST: begin
                    r_gnt <= '0;
                    r_gap <= r_gap + 1'b1;
                end
                default: begin
                    r_gnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: a default-parameter instance and a
// fast instance (CLK_DIV=2, PRE_CLKS=1, GAP=0), each with a posedge-only slave.
module tb_spi_master_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Instance A: default parameters
    logic [1:0]  req_a;
    logic [15:0] tx0_a, tx1_a;
    logic [1:0]  gnt_a, done_a;
    logic [15:0] rx_a;
    logic        busy_a, sck_a, csb_a, mosi_a, miso_a;

    spi_master_arbiter dut_a (
        .CLK_50(clk), .RST(rst), .REQ(req_a), .TX_DATA0(tx0_a), .TX_DATA1(tx1_a),
        .GNT(gnt_a), .DONE(done_a), .RX_DATA(rx_a), .BUSY(busy_a),
        .SCK(sck_a), .CSbar(csb_a), .MOSI(mosi_a), .MISO(miso_a)
    );

    // Instance B: fast timing
    logic [1:0]  req_b;
    logic [15:0] tx0_b, tx1_b;
    logic [1:0]  gnt_b, done_b;
    logic [15:0] rx_b;
    logic        busy_b, sck_b, csb_b, mosi_b, miso_b;

    spi_master_arbiter #(.CLK_DIV(2), .PRE_CLKS(1), .GAP(0)) dut_b (
        .CLK_50(clk), .RST(rst), .REQ(req_b), .TX_DATA0(tx0_b), .TX_DATA1(tx1_b),
        .GNT(gnt_b), .DONE(done_b), .RX_DATA(rx_b), .BUSY(busy_b),
        .SCK(sck_b), .CSbar(csb_b), .MOSI(mosi_b), .MISO(miso_b)
    );

    // Slave model A: loads its word on preamble edges, shifts on CSbar-low edges
    logic [15:0] sa_word = '0, sa_out = '0, sa_in = '0;
    logic        sa_miso = 1'b0, sa_pad = 1'b1;
    int          sa_rises = 0, sa_low = 0;
    assign miso_a = sa_miso;
    always @(posedge sck_a) begin
        sa_rises <= sa_rises + 1;
        if (csb_a) begin
            sa_out  <= sa_word;
            sa_miso <= 1'b0;
            sa_low  <= 0;
        end else begin
            if (sa_low == 0) sa_pad <= mosi_a;
            sa_low  <= sa_low + 1;
            sa_miso <= sa_out[15];
            sa_out  <= {sa_out[14:0], 1'b0};
            sa_in   <= {sa_in[14:0], mosi_a};
        end
    end

    // Slave model B
    logic [15:0] sb_word = '0, sb_out = '0, sb_in = '0;
    logic        sb_miso = 1'b0;
    assign miso_b = sb_miso;
    always @(posedge sck_b) begin
        if (csb_b) begin
            sb_out  <= sb_word;
            sb_miso <= 1'b0;
        end else begin
            sb_miso <= sb_out[15];
            sb_out  <= {sb_out[14:0], 1'b0};
            sb_in   <= {sb_in[14:0], mosi_b};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (failures so far %0d)", tag, obs, exp, n_fail);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic [1:0] gnt_of(input bit sel);
        return sel ? gnt_b : gnt_a;
    endfunction

    function automatic logic [1:0] done_of(input bit sel);
        return sel ? done_b : done_a;
    endfunction

    task automatic wait_gnt(input bit sel, output int t);
        t = -1;
        #1;
        for (int i = 0; i < 400; i++) begin
            if (gnt_of(sel) != 2'b00) begin
                t = cyc;
                return;
            end
            step(1);
        end
    endtask

    task automatic wait_done(input bit sel, input logic [1:0] g, output int t, output int bad);
        t = -1;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            if (done_of(sel) != 2'b00) begin
                t = cyc;
                return;
            end
            if (gnt_of(sel) != g) bad++;
            step(1);
        end
    endtask

    initial begin
        int tg, td, td_prev, bad, snap, cnt, t1, t2;
        logic [1:0]  exp_g;
        logic [15:0] exp_tx;
        logic        prev;

        rst = 1'b1;
        req_a = '0; tx0_a = '0; tx1_a = '0;
        req_b = '0; tx0_b = '0; tx1_b = '0;
        step(3);
        rst = 1'b0;
        step(2);

        check("rst_gnt",   {30'd0, gnt_a}, 32'd0);
        check("rst_done",  {30'd0, done_a}, 32'd0);
        check("rst_rx",    {16'd0, rx_a}, 32'd0);
        check("rst_lines", {28'd0, busy_a, sck_a, csb_a, mosi_a}, 32'b0010);
        check("rst_b_lines", {28'd0, busy_b, sck_b, csb_b, mosi_b}, 32'b0010);

        // Contention: both clients request continuously
        tx0_a = 16'h1234; tx1_a = 16'hABCD; sa_word = 16'h0FF0;
        req_a = 2'b11;
        td_prev = 0;
        for (int f = 0; f < 4; f++) begin
            exp_g  = (f % 2 == 0) ? 2'b01 : 2'b10;
            exp_tx = (f % 2 == 0) ? 16'h1234 : 16'hABCD;
            wait_gnt(1'b0, tg);
            check("cont_gnt", {30'd0, gnt_a}, {30'd0, exp_g});
            if (f > 0) check("cont_regrant_gap", tg - td_prev, 32'd8);
            wait_done(1'b0, exp_g, td, bad);
            check("cont_done_lat", td - tg, 32'd153);
            check("cont_done_bit", {30'd0, done_a}, {30'd0, exp_g});
            check("cont_slave_rx", {16'd0, sa_in}, {16'd0, exp_tx});
            check("cont_rx", {16'd0, rx_a}, 32'h0FF0);
            check("cont_gnt_held", bad, 32'd0);
            if (f > 0) check("cont_done_spacing", td - td_prev, 32'd161);
            td_prev = td;
            step(1);
            check("cont_gnt_drop", {30'd0, gnt_a}, 32'd0);
        end
        req_a = 2'b00;
        step(10);

        // Single request with defaults
        tx0_a = 16'hA5C3; sa_word = 16'h3C5A;
        req_a = 2'b01;
        wait_gnt(1'b0, tg);
        snap = sa_rises;
        check("single_gnt", {30'd0, gnt_a}, 32'b01);
        wait_done(1'b0, 2'b01, td, bad);
        check("single_done_lat", td - tg, 32'd153);
        check("single_done_bit", {30'd0, done_a}, 32'b01);
        check("single_rx", {16'd0, rx_a}, 32'h3C5A);
        check("single_slave_rx", {16'd0, sa_in}, 32'hA5C3);
        check("single_rises", sa_rises - snap, 32'd19);
        check("single_low_rises", sa_low, 32'd17);
        check("single_gnt_held", bad, 32'd0);
        check("single_csb_at_done", {31'd0, csb_a}, 32'd1);
        req_a = 2'b00;
        step(1);
        check("single_done_pulse", {30'd0, done_a}, 32'd0);
        check("single_gnt_drop", {30'd0, gnt_a}, 32'd0);
        check("single_rx_hold", {16'd0, rx_a}, 32'h3C5A);
        step(10);

        // Request withdrawn 20 cycles after grant
        tx0_a = 16'h5AA5; sa_word = 16'h1111;
        req_a = 2'b01;
        wait_gnt(1'b0, tg);
        step(20);
        req_a = 2'b00;
        wait_done(1'b0, 2'b01, td, bad);
        check("wd_done_lat", td - tg, 32'd153);
        check("wd_done_bit", {30'd0, done_a}, 32'b01);
        check("wd_slave_rx", {16'd0, sa_in}, 32'h5AA5);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (gnt_a != 2'b00 || done_a != 2'b00) cnt++;
        end
        check("wd_no_regrant", cnt, 32'd0);

        // Reset in the middle of SHIFT
        tx0_a = 16'h7E81; sa_word = 16'h2222;
        req_a = 2'b01;
        wait_gnt(1'b0, tg);
        for (int i = 0; i < 300 && sa_low != 8; i++) step(1);
        check("mid_bit8_reached", sa_low, 32'd8);
        rst = 1'b1;
        #1;
        check("mid_rst_lines", {28'd0, busy_a, sck_a, csb_a, mosi_a}, 32'b0010);
        check("mid_rst_gnt", {30'd0, gnt_a}, 32'd0);
        check("mid_rst_done", {30'd0, done_a}, 32'd0);
        step(3);
        req_a = 2'b00;
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (done_a != 2'b00) cnt++;
        end
        check("mid_no_done", cnt, 32'd0);
        check("mid_rx_cleared", {16'd0, rx_a}, 32'd0);
        tx1_a = 16'hC3A5; sa_word = 16'h9966;
        req_a = 2'b10;
        wait_gnt(1'b0, tg);
        check("post_rst_gnt", {30'd0, gnt_a}, 32'b10);
        wait_done(1'b0, 2'b10, td, bad);
        check("post_rst_done_lat", td - tg, 32'd153);
        check("post_rst_done_bit", {30'd0, done_a}, 32'b10);
        check("post_rst_rx", {16'd0, rx_a}, 32'h9966);
        check("post_rst_slave_rx", {16'd0, sa_in}, 32'hC3A5);
        req_a = 2'b00;
        step(10);

        // Pad bit precedes an all-ones word
        tx0_a = 16'hFFFF; sa_word = 16'h0001;
        req_a = 2'b01;
        wait_gnt(1'b0, tg);
        wait_done(1'b0, 2'b01, td, bad);
        check("pad_bit", {31'd0, sa_pad}, 32'd0);
        check("pad_slave_rx", {16'd0, sa_in}, 32'hFFFF);
        check("pad_low_rises", sa_low, 32'd17);
        check("pad_rx", {16'd0, rx_a}, 32'h0001);
        req_a = 2'b00;
        step(10);

        // Fast instance: CLK_DIV=2, PRE_CLKS=1, GAP=0
        tx0_b = 16'h0F0F; sb_word = 16'hF00F;
        req_b = 2'b01;
        wait_gnt(1'b1, tg);
        t1 = -1; t2 = -1; prev = sck_b;
        for (int i = 0; i < 40 && t2 < 0; i++) begin
            step(1);
            if (sck_b && !prev) begin
                if (t1 < 0) t1 = cyc;
                else t2 = cyc;
            end
            prev = sck_b;
        end
        check("b_sck_period", t2 - t1, 32'd4);
        wait_done(1'b1, 2'b01, td, bad);
        check("b_done_lat", td - tg, 32'd73);
        check("b_done_bit", {30'd0, done_b}, 32'b01);
        check("b_rx", {16'd0, rx_b}, 32'hF00F);
        check("b_slave_rx", {16'd0, sb_in}, 32'h0F0F);
        tx0_b = 16'h1357;
        step(1);
        check("b_regrant_idle", {31'd0, busy_b}, 32'd0);
        check("b_regrant_gnt", {30'd0, gnt_b}, 32'b01);
        tg = cyc;
        check("b_regrant_cycle", tg - td, 32'd1);
        wait_done(1'b1, 2'b01, td, bad);
        check("b2_done_lat", td - tg, 32'd73);
        check("b2_slave_rx", {16'd0, sb_in}, 32'h1357);
        check("b2_rx", {16'd0, rx_b}, 32'hF00F);
        req_b = 2'b00;
        step(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Two-requester SPI master that shares one SPI link to the 16-bit SPI slave device (GPIO_0 SCK/CSbar/MOSI/MISO) between two on-chip clients. It grants the link round-robin and generates SCK, CSbar and MOSI from the system clock. Each frame writes one 16-bit word and captures the 16-bit word returned on MISO. It matches the slave's posedge-only protocol: the slave needs preamble clocks with CSbar high, then 17 SCK cycles with CSbar low.

## Interface
- CLK_DIV, default 4: SCK half-period in CLK_50 cycles; legal range ≥2.
- PRE_CLKS, default 2: number of full SCK cycles with CSbar high before each frame. These let the slave load its output word.
- GAP, default 8: number of idle CLK_50 cycles after each frame, with CSbar high and SCK low.
- CLK_50  in  1: system clock; all logic on its rising edge.
- RST  in  1: asynchronous, active-high reset.
- REQ  in  2: level request per client; held until that client's DONE bit.
- TX_DATA0 / TX_DATA1  in  16 each: word to send for client 0 / client 1; latched at grant.
- GNT  out  2: one-hot, high from the grant cycle through the DONE cycle.
- DONE  out  2: 1-cycle pulse on the owning client's bit at frame end.
- RX_DATA  out  16: word captured from MISO; updated only in the DONE cycle, then held.
- BUSY  out  1: high in every state except IDLE.
- SCK  out  1: SPI clock, idle low.
- CSbar  out  1: active-low chip select, idle high.
- MOSI  out  1: master data out.
- MISO  in  1: slave data in.

## Operation
- State machine: IDLE → PRE → SHIFT → POST → IDLE.
- IDLE:
  - SCK=0, CSbar=1.
  - If any REQ bit is high: grant it, latch that client's TX_DATA into the 17-bit shift register as {1'b0, TX}, set GNT, and go to PRE next cycle.
- Arbitration:
  - A last-served pointer resets to 1, so client 0 wins the first contention.
  - If both clients request, grant the one that is not last-served.
  - Update the pointer at grant.
- PRE:
  - SCK toggles every CLK_DIV cycles, starting low, for PRE_CLKS full cycles.
  - CSbar=1, MOSI=0.
- SHIFT:
  - CSbar=0 for exactly 17 SCK cycles.
  - MOSI presents shift-register bit 16 (the pad bit) at entry, then advances one bit on each SCK falling edge.
  - Order is pad, then TX[15] … TX[0]. The slave keeps the last 16 bits, i.e. TX.
- MISO capture:
  - Sample MISO in the last CLK_50 cycle of each SCK low phase, i.e. just before each rising edge.
  - Discard the sample before rising edge 1 (MISO is Z/stale at that point).
  - Samples before rising edges 2..17 give RX[15]..RX[0], MSB first.
- End of SHIFT:
  - After the 17th falling edge, in the same cycle: CSbar=1, DONE[owner]=1, RX_DATA updated.
  - GNT drops the following cycle.
- POST:
  - GAP cycles with SCK=0 and CSbar=1, then IDLE.
  - REQ is not sampled in POST.
- REQ dropped after grant: the frame completes and DONE still pulses. REQ low in IDLE is simply ignored.
- A client holding REQ through POST is re-arbitrated; if the other client is requesting, it goes first.
- Reset, asynchronous at any time including mid-SHIFT, forces:
  - state IDLE, SCK=0, CSbar=1, MOSI=0;
  - GNT=0, DONE=0, RX_DATA=0, BUSY=0;
  - pointer=1, bit counters=0.
  - No DONE is issued for the aborted frame.

## Timing
- SCK period is 2·CLK_DIV cycles; duty cycle 50%.
- Counts per frame: PRE_CLKS+17 rising edges; exactly 17 falling edges with CSbar low.
- Grant in cycle T → DONE at T+1+(PRE_CLKS+17)·2·CLK_DIV. With defaults this is T+153.
- Earliest next grant: DONE cycle + GAP. With defaults this is T+161.
- CSbar falls coincident with the SCK falling edge that ends PRE. It rises coincident with DONE.
- MOSI changes only on SCK falling edges (or at SHIFT entry). It is stable for ≥CLK_DIV cycles around every rising edge.
- MISO is sampled ≥CLK_DIV−1 cycles after the slave's update edge, so no synchronizer is used. CLK_DIV≥2 is required for this.
- Counters: the half-period counter spans CLK_DIV; the bit counter is 5 bits (0..16); the PRE counter spans PRE_CLKS.

## Test plan
- Single request, defaults:
  - Stimulus: REQ=01, TX_DATA0=16'hA5C3, slave model returns 16'h3C5A.
  - Required: 19 SCK rising edges; MOSI bits after pad = A5C3; DONE=01 at grant+153; RX_DATA=3C5A; GNT=01 during frame.
- Contention:
  - Stimulus: REQ=11 held continuously.
  - Required: GNT sequence 01,10,01,10; each DONE 161 cycles apart; TX_DATA0 and TX_DATA1 both delivered correctly.
- Request withdrawn:
  - Stimulus: REQ0 dropped 20 cycles after grant.
  - Required: frame completes, DONE=01 still pulses, and no second grant.
- Reset mid-SHIFT:
  - Stimulus: RST asserted at bit 8.
  - Required: same cycle SCK=0, CSbar=1, MOSI=0, GNT=0, BUSY=0, no DONE. After release, REQ=10 gives client 1 a full correct frame.
- CLK_DIV=2, PRE_CLKS=1, GAP=0:
  - Required: SCK period 4; DONE at grant+73; RX correct against the slave model; immediate regrant in the cycle after POST.
- Pad-bit check:
  - Stimulus: TX_DATA0=16'hFFFF.
  - Required: MOSI=0 at rising edge 1 of SHIFT, 1 at edges 2..17; slave model receives FFFF.
